// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU sequencing controller.
// Included by the decoder and the FSM so both agree on field meanings.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        GET_A     = 3'd2,
        GET_B     = 3'd3,
        EXEC      = 3'd4,
        WRITE_REG = 3'd5,
        WRITE_IMM = 3'd6
    } state_t;

    // Which path through the datapath an instruction needs after DECODE
    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_IMM     = 2'd1,
        CLS_B_ONLY  = 2'd2,
        CLS_A_B     = 2'd3
    } instr_class_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational decode of the latched instruction: fields, sign-extended
// immediate and the next-state class used by the FSM in DECODE.
module ctrl_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [1:0]         op,
    output logic [1:0]         sh,
    output logic [15:0]        sximm8,
    output instr_class_t       cls,
    output logic               is_cmp,
    output logic               is_mov_reg
);

    logic [2:0] opcode;
    logic       unused_fields;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign sh     = ir[4:3];
    assign sximm8 = sext8(ir[7:0]);

    // Register numbers travel to the register file via the nsel mux, not here
    assign unused_fields = ^ir[10:5];

    assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);

    always_comb begin
        cls = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)
                cls = CLS_IMM;
            else if (op == OP_MOV_REG)
                cls = CLS_B_ONLY;
        end else if (opcode == OPC_ALU) begin
            if (op == OP_MVN)
                cls = CLS_B_ONLY;
            else
                cls = CLS_A_B;
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Moore FSM sequencing register file, A/B/C registers, shifter, ALU and status
// register for one instruction per accepted start pulse.
//   state     | meaning
//   WAIT      | idle, w=1, accept s and latch instr
//   DECODE    | pick the datapath path from the latched instruction
//   GET_A     | read Rn into A
//   GET_B     | read Rm into B
//   EXEC      | ALU/shifter run; load C, or status for CMP
//   WRITE_REG | write C to Rd
//   WRITE_IMM | write sximm8 to Rn
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int NSEL_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s,
    input  logic [INSTR_W-1:0] instr,
    output logic               w,
    output logic [NSEL_W-1:0]  nsel,
    output logic               readnum_sel_valid,
    output logic               write,
    output logic [1:0]         vsel,
    output logic               loada,
    output logic               loadb,
    output logic               asel,
    output logic               bsel,
    output logic               loadc,
    output logic               loads,
    output logic [1:0]         ALUop,
    output logic [1:0]         shift,
    output logic [15:0]        sximm8
);

    state_t            state;
    state_t            state_next;
    logic [INSTR_W-1:0] ir;

    logic [1:0]        dec_op;
    logic [1:0]        dec_sh;
    instr_class_t      dec_cls;
    logic              dec_is_cmp;
    logic              dec_is_mov_reg;

    ctrl_decoder #(
        .INSTR_W (INSTR_W)
    ) u_dec (
        .ir         (ir),
        .op         (dec_op),
        .sh         (dec_sh),
        .sximm8     (sximm8),
        .cls        (dec_cls),
        .is_cmp     (dec_is_cmp),
        .is_mov_reg (dec_is_mov_reg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == WAIT && s)
                ir <= instr;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT:      if (s) state_next = DECODE;
            DECODE: begin
                case (dec_cls)
                    CLS_IMM:    state_next = WRITE_IMM;
                    CLS_B_ONLY: state_next = GET_B;
                    CLS_A_B:    state_next = GET_A;
                    default:    state_next = WAIT;
                endcase
            end
            GET_A:     state_next = GET_B;
            GET_B:     state_next = EXEC;
            EXEC:      state_next = dec_is_cmp ? WAIT : WRITE_REG;
            WRITE_REG: state_next = WAIT;
            WRITE_IMM: state_next = WAIT;
            default:   state_next = WAIT;
        endcase
    end

    always_comb begin
        w     = 1'b0;
        nsel  = NSEL_W'(NSEL_NONE);
        write = 1'b0;
        vsel  = VSEL_C;
        loada = 1'b0;
        loadb = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        ALUop = ALU_ADD;
        shift = 2'b00;
        case (state)
            WAIT:  w = 1'b1;
            GET_A: begin
                nsel  = NSEL_W'(NSEL_RN);
                loada = 1'b1;
            end
            GET_B: begin
                nsel  = NSEL_W'(NSEL_RM);
                loadb = 1'b1;
            end
            EXEC: begin
                shift = dec_sh;
                // MOV reg passes B through the adder with A forced to zero
                if (dec_is_mov_reg) begin
                    ALUop = ALU_ADD;
                    asel  = 1'b1;
                end else begin
                    ALUop = dec_op;
                end
                if (dec_is_cmp)
                    loads = 1'b1;
                else
                    loadc = 1'b1;
            end
            WRITE_REG: begin
                nsel  = NSEL_W'(NSEL_RD);
                vsel  = VSEL_C;
                write = 1'b1;
            end
            WRITE_IMM: begin
                nsel  = NSEL_W'(NSEL_RN);
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            default: ;
        endcase
        readnum_sel_valid = |nsel;
    end

endmodule
